slow_peripheral_strobe_adapter: RTL and testbench
=================================================

# slow_peripheral_strobe_adapter

Single-clock adapter sitting directly downstream of the slow-peripheral clock-crossing bridge's master port. It accepts 32-bit Avalon-MM reads and writes on the bridge's master clock. Each transfer is replayed as an asynchronous-style chipselect/read_n/write_n cycle with programmable setup, strobe and hold lengths, stretched by a peripheral ready input and bounded by a timeout. Read data returns to the bridge through readdatavalid.

## Interface
Parameters:
- SETUP_CYCLES, 1: address/chipselect valid before strobe (1..255).
- STROBE_CYCLES, 3: minimum read_n/write_n low time (1..255).
- HOLD_CYCLES, 1: address/data held after strobe release (1..255).
- TIMEOUT_CYCLES, 255: extra strobe cycles allowed while p_ready low (1..255).

Ports:
- clk  in  1  master-domain clock.
- reset_n  in  1  reset; asynchronous, active-low.
- s_address  in  8  byte address from the bridge; bits [1:0] are ignored.
- s_byteenable  in  4  byte lanes.
- s_read, s_write  in  1  transfer requests; never both high.
- s_writedata  in  32  write data.
- s_waitrequest  out  1  stall, combinational.
- s_readdata  out  32  registered read data.
- s_readdatavalid  out  1  one-cycle read-return pulse.
- s_endofpacket  out  1  tied 0.
- p_address  out  6  word address, equal to s_address[7:2].
- p_byteenable_n  out  4  active-low byte lanes.
- p_chipselect_n, p_read_n, p_write_n  out  1  active-low strobes.
- p_writedata  out  32  write data, driven for the whole cycle.
- p_readdata  in  32  peripheral read data.
- p_ready  in  1  peripheral ready; low stretches the strobe.
- timeout_pulse  out  1  one-cycle pulse on a forced completion.

## Operation
- States: IDLE, SETUP, STROBE, HOLD. An 8-bit down-counter cnt and an 8-bit extension counter ext.
- Outputs at reset:
  - p_*_n = 1; p_address, p_writedata = 0.
  - s_readdata = 0; s_readdatavalid = 0; timeout_pulse = 0.
  - State = IDLE.
- IDLE:
  - s_waitrequest = s_read | s_write.
  - On a request: latch address, byteenable, writedata and direction; cnt = SETUP_CYCLES-1; go to SETUP.
- SETUP:
  - p_chipselect_n = 0, p_address valid.
  - At cnt = 0: cnt = STROBE_CYCLES-1, ext = 0, go to STROBE. Otherwise decrement cnt.
- STROBE:
  - p_read_n or p_write_n = 0, according to the latched direction.
  - At cnt = 0 with p_ready = 1: capture p_readdata (reads only); cnt = HOLD_CYCLES-1; go to HOLD.
  - At cnt = 0 with p_ready = 0: increment ext.
  - When ext reaches TIMEOUT_CYCLES with p_ready still 0: capture 32'hFFFF_FFFF for reads; pulse timeout_pulse; go to HOLD.
  - p_ready is ignored while cnt ≠ 0.
- HOLD:
  - Strobes are high, chipselect stays low, address and data remain stable.
  - At cnt = 0: s_waitrequest = 0, which accepts the held request; go to IDLE.
  - Otherwise s_waitrequest = 1 and cnt decrements.
- s_waitrequest is 1 in SETUP and STROBE, and in HOLD except on its last cycle.
- Read return: s_readdatavalid = 1 in the cycle after acceptance, with s_readdata holding the captured value. Writes never pulse s_readdatavalid.
- The request must stay asserted with unchanged fields until accepted. Changes made after IDLE are ignored because the fields are latched.
- Reset mid-transfer: all strobes deassert immediately, and no readdatavalid pulse is issued for the aborted transfer.

## Timing
- Request first seen in cycle 0 → accepted in cycle SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES+E, where E is the number of ready-extension cycles.
- s_readdatavalid follows one cycle after acceptance.
- Defaults, read, p_ready = 1:
  - Cycle 0: IDLE, waitrequest = 1.
  - Cycle 1: SETUP.
  - Cycles 2–4: p_read_n low; p_readdata sampled at the end of cycle 4.
  - Cycle 5: HOLD, waitrequest = 0.
  - Cycle 6: readdatavalid = 1.
- Back-to-back: a new request presented in the cycle after acceptance is seen in IDLE. Throughput is one transfer per SETUP+STROBE+HOLD+1 cycles.
- Idle bus with no request: s_waitrequest = 0, so the bridge FIFO read logic is never blocked.
- readdatavalid of transfer N may coincide with IDLE detection of transfer N+1; both proceed.

## Test plan
- Defaults; write 0x12345678 to byte address 0x10 with byteenable 0xF, p_ready = 1:
  - p_address = 0x04 and p_byteenable_n = 0x0.
  - p_write_n low for exactly cycles 2–4.
  - Accepted in cycle 5; no readdatavalid.
- Read from address 0x3C with p_readdata = 0xCAFEF00D:
  - p_read_n low for cycles 2–4.
  - Accepted in cycle 5; readdatavalid with 0xCAFEF00D in cycle 6.
- Read with p_ready held low for 4 extra cycles: acceptance moves to cycle 9, readdatavalid to cycle 10, timeout_pulse stays 0.
- TIMEOUT_CYCLES = 8, p_ready stuck low on a read:
  - timeout_pulse pulses once.
  - Readdata = 0xFFFFFFFF; acceptance in cycle 13.
- Three back-to-back writes and reads alternating:
  - Each transfer takes 6 cycles from detection to the next detection.
  - Exactly one readdatavalid pulse per read, in order.
- reset_n asserted during STROBE of a read: strobes go high asynchronously, no readdatavalid follows, and a subsequent read completes normally.

Source files
------------

// File: rtl/slow_peripheral_strobe_adapter.sv
// Replays Avalon-MM reads/writes from the clock-crossing bridge as a
// chipselect/read_n/write_n cycle with programmable setup, strobe and hold.
`timescale 1ns/1ps

module slow_peripheral_strobe_adapter #(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned STROBE_CYCLES  = 3,
    parameter int unsigned HOLD_CYCLES    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [7:0]  s_address,
    input  logic [3:0]  s_byteenable,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic        s_waitrequest,
    output logic [31:0] s_readdata,
    output logic        s_readdatavalid,
    output logic        s_endofpacket,

    output logic [5:0]  p_address,
    output logic [3:0]  p_byteenable_n,
    output logic        p_chipselect_n,
    output logic        p_read_n,
    output logic        p_write_n,
    output logic [31:0] p_writedata,
    input  logic [31:0] p_readdata,
    input  logic        p_ready,

    output logic        timeout_pulse
);

    localparam int unsigned CW = 8;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] EXT_LIMIT   = CW'(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] TIMEOUT_DATA = {DW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   ext_q;
    logic            is_read_q;

    logic [AW-1:0]   p_address_q;
    logic [3:0]      p_byteenable_n_q;
    logic            p_chipselect_n_q;
    logic            p_read_n_q;
    logic            p_write_n_q;
    logic [DW-1:0]   p_writedata_q;
    logic [DW-1:0]   s_readdata_q;
    logic            s_readdatavalid_q;
    logic            timeout_pulse_q;

    logic            req;
    logic            cnt_zero;
    logic            unused_addr_bits;

    assign req      = s_read | s_write;
    assign cnt_zero = (cnt_q == '0);

    // Byte-offset bits have no meaning on a word-wide peripheral.
    assign unused_addr_bits = ^s_address[1:0];

    // Stall is combinational so an idle bus never blocks the bridge.
    always_comb begin
        s_waitrequest = 1'b1;
        unique case (state_q)
            ST_IDLE:   s_waitrequest = req;
            ST_HOLD:   s_waitrequest = !cnt_zero;
            default:   s_waitrequest = 1'b1;
        endcase
    end

    // Sequencer; every peripheral-side output changes on the state edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            ext_q             <= '0;
            is_read_q         <= 1'b0;
            p_address_q       <= '0;
            p_byteenable_n_q  <= '1;
            p_chipselect_n_q  <= 1'b1;
            p_read_n_q        <= 1'b1;
            p_write_n_q       <= 1'b1;
            p_writedata_q     <= '0;
            s_readdata_q      <= '0;
            s_readdatavalid_q <= 1'b0;
            timeout_pulse_q   <= 1'b0;
        end else begin
            s_readdatavalid_q <= 1'b0;
            timeout_pulse_q   <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        p_address_q      <= s_address[7:2];
                        p_byteenable_n_q <= ~s_byteenable;
                        p_writedata_q    <= s_writedata;
                        is_read_q        <= s_read;
                        p_chipselect_n_q <= 1'b0;
                        cnt_q            <= SETUP_LOAD;
                        state_q          <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (cnt_zero) begin
                        cnt_q       <= STROBE_LOAD;
                        ext_q       <= '0;
                        p_read_n_q  <= !is_read_q;
                        p_write_n_q <= is_read_q;
                        state_q     <= ST_STROBE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                ST_STROBE: begin
                    // p_ready only matters once the minimum strobe has elapsed.
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (p_ready) begin
                        if (is_read_q) begin
                            s_readdata_q <= p_readdata;
                        end
                        cnt_q       <= HOLD_LOAD;
                        p_read_n_q  <= 1'b1;
                        p_write_n_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else if (ext_q == EXT_LIMIT) begin
                        if (is_read_q) begin
                            s_readdata_q <= TIMEOUT_DATA;
                        end
                        timeout_pulse_q <= 1'b1;
                        cnt_q           <= HOLD_LOAD;
                        p_read_n_q      <= 1'b1;
                        p_write_n_q     <= 1'b1;
                        state_q         <= ST_HOLD;
                    end else begin
                        ext_q <= ext_q + CW'(1);
                    end
                end

                ST_HOLD: begin
                    // Last hold cycle is the acceptance cycle on the Avalon side.
                    if (cnt_zero) begin
                        p_chipselect_n_q  <= 1'b1;
                        p_byteenable_n_q  <= '1;
                        s_readdatavalid_q <= is_read_q;
                        state_q           <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_readdata      = s_readdata_q;
    assign s_readdatavalid = s_readdatavalid_q;
    assign s_endofpacket   = 1'b0;
    assign p_address       = p_address_q;
    assign p_byteenable_n  = p_byteenable_n_q;
    assign p_chipselect_n  = p_chipselect_n_q;
    assign p_read_n        = p_read_n_q;
    assign p_write_n       = p_write_n_q;
    assign p_writedata     = p_writedata_q;
    assign timeout_pulse   = timeout_pulse_q;

endmodule

// File: tb/tb_slow_peripheral_strobe_adapter.sv
// Bench for slow_peripheral_strobe_adapter: three parameterisations, each
// checked cycle by cycle against a timing model derived from the transfer rules.
`timescale 1ns/1ps

module tb_slow_peripheral_strobe_adapter;

    localparam int NI = 3;
    localparam int unsigned SET_C [NI] = '{1, 1, 2};
    localparam int unsigned STR_C [NI] = '{3, 3, 1};
    localparam int unsigned HLD_C [NI] = '{1, 1, 3};
    localparam int unsigned TMO_C [NI] = '{255, 8, 2};

    logic        clk = 1'b0;
    logic        reset_n;

    logic [7:0]  s_address       [NI];
    logic [3:0]  s_byteenable    [NI];
    logic        s_read          [NI];
    logic        s_write         [NI];
    logic [31:0] s_writedata     [NI];
    logic        s_waitrequest   [NI];
    logic [31:0] s_readdata      [NI];
    logic        s_readdatavalid [NI];
    logic        s_endofpacket   [NI];
    logic [5:0]  p_address       [NI];
    logic [3:0]  p_byteenable_n  [NI];
    logic        p_chipselect_n  [NI];
    logic        p_read_n        [NI];
    logic        p_write_n       [NI];
    logic [31:0] p_writedata     [NI];
    logic [31:0] p_readdata      [NI];
    logic        p_ready         [NI];
    logic        timeout_pulse   [NI];

    int          n_checks = 0;
    int          n_pass   = 0;

    // Read return owed in the cycle following each instance's last acceptance.
    bit          pending_rdv  [NI];
    logic [31:0] pending_data [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        slow_peripheral_strobe_adapter #(
            .SETUP_CYCLES   (SET_C[g]),
            .STROBE_CYCLES  (STR_C[g]),
            .HOLD_CYCLES    (HOLD_C_SEL(g)),
            .TIMEOUT_CYCLES (TMO_C[g])
        ) u_dut (
            .clk             (clk),
            .reset_n         (reset_n),
            .s_address       (s_address[g]),
            .s_byteenable    (s_byteenable[g]),
            .s_read          (s_read[g]),
            .s_write         (s_write[g]),
            .s_writedata     (s_writedata[g]),
            .s_waitrequest   (s_waitrequest[g]),
            .s_readdata      (s_readdata[g]),
            .s_readdatavalid (s_readdatavalid[g]),
            .s_endofpacket   (s_endofpacket[g]),
            .p_address       (p_address[g]),
            .p_byteenable_n  (p_byteenable_n[g]),
            .p_chipselect_n  (p_chipselect_n[g]),
            .p_read_n        (p_read_n[g]),
            .p_write_n       (p_write_n[g]),
            .p_writedata     (p_writedata[g]),
            .p_readdata      (p_readdata[g]),
            .p_ready         (p_ready[g]),
            .timeout_pulse   (timeout_pulse[g])
        );
    end

    function automatic int unsigned HOLD_C_SEL(input int g);
        return HLD_C[g];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // {waitrequest, chipselect_n, read_n, write_n, readdatavalid, timeout_pulse, endofpacket}
    function automatic logic [6:0] sig(input int k);
        return {s_waitrequest[k], p_chipselect_n[k], p_read_n[k], p_write_n[k],
                s_readdatavalid[k], timeout_pulse[k], s_endofpacket[k]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int k, input int n);
        logic [6:0] exp_sig;
        for (int c = 0; c < n; c++) begin
            s_read[k]     = 1'b0;
            s_write[k]    = 1'b0;
            p_ready[k]    = 1'($urandom_range(0, 1));
            p_readdata[k] = $urandom;
            @(negedge clk);
            exp_sig = {1'b0, 1'b1, 1'b1, 1'b1, pending_rdv[k], 1'b0, 1'b0};
            check($sformatf("i%0d idle sig", k), 64'(sig(k)), 64'(exp_sig));
            if (pending_rdv[k])
                check($sformatf("i%0d idle rdata", k), 64'(s_readdata[k]), 64'(pending_data[k]));
            pending_rdv[k] = 1'b0;
            next_cycle();
        end
    endtask

    // One transfer; rl = cycles p_ready is held low from the first cycle it is honoured.
    task automatic xfer(input int k, input bit rd, input logic [7:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int rl, input bit fix_pd, input logic [31:0] pd_fix);
        int s, t, h, to, e, a;
        bit tmo, stb;
        logic [31:0] pd, cap;
        logic [6:0] exp_sig;
        s   = int'(SET_C[k]);
        t   = int'(STR_C[k]);
        h   = int'(HLD_C[k]);
        to  = int'(TMO_C[k]);
        tmo = (rl > to);
        e   = tmo ? to : rl;
        a   = s + t + h + e;
        cap = 32'hFFFF_FFFF;
        for (int c = 0; c <= a; c++) begin
            s_read[k]       = rd;
            s_write[k]      = !rd;
            s_address[k]    = addr;
            s_byteenable[k] = be;
            s_writedata[k]  = wd;
            pd = fix_pd ? pd_fix : $urandom;
            p_readdata[k] = pd;
            if (c == s + t + e && !tmo) cap = pd;
            if (c < s + t)           p_ready[k] = 1'($urandom_range(0, 1));
            else if (c < s + t + rl) p_ready[k] = 1'b0;
            else                     p_ready[k] = 1'b1;
            @(negedge clk);
            stb = (c >= s + 1) && (c <= s + t + e);
            exp_sig = {(c < a), (c < 1), !(rd && stb), !(!rd && stb),
                       (c == 0) && pending_rdv[k], tmo && (c == s + t + e + 1), 1'b0};
            check($sformatf("i%0d c%0d sig", k, c), 64'(sig(k)), 64'(exp_sig));
            if (c == 0 && pending_rdv[k])
                check($sformatf("i%0d rdata", k), 64'(s_readdata[k]), 64'(pending_data[k]));
            if (c >= 1)
                check($sformatf("i%0d c%0d addr/be", k, c),
                      64'({p_address[k], p_byteenable_n[k]}), 64'({addr[7:2], ~be}));
            if (c == s + 1)
                check($sformatf("i%0d wdata", k), 64'(p_writedata[k]), 64'(wd));
            next_cycle();
        end
        s_read[k]       = 1'b0;
        s_write[k]      = 1'b0;
        pending_rdv[k]  = rd;
        pending_data[k] = cap;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, rl, to;
        reset_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            s_address[k] = '0; s_byteenable[k] = '0; s_read[k] = 1'b0; s_write[k] = 1'b0;
            s_writedata[k] = '0; p_readdata[k] = '0; p_ready[k] = 1'b1;
            pending_rdv[k] = 1'b0; pending_data[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("i%0d reset sig", k), 64'(sig(k)), 64'(7'b0111000));
            check($sformatf("i%0d reset paddr/be", k),
                  64'({p_address[k], p_byteenable_n[k]}), 64'({6'h00, 4'hF}));
            check($sformatf("i%0d reset data", k), 64'({p_writedata[k], s_readdata[k]}), 64'(0));
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        next_cycle();

        // Directed: write, read, ready-stretched read, timeouts.
        xfer(0, 1'b0, 8'h10, 4'hF, 32'h1234_5678, 0, 1'b1, 32'h0);
        idle_cycles(0, 1);
        xfer(0, 1'b1, 8'h3C, 4'hF, 32'h0, 0, 1'b1, 32'hCAFE_F00D);
        idle_cycles(0, 2);
        xfer(0, 1'b1, 8'h23, 4'h5, 32'h0, 4, 1'b0, 32'h0);
        idle_cycles(0, 2);
        xfer(1, 1'b1, 8'h44, 4'hF, 32'h0, 20, 1'b0, 32'h0);
        idle_cycles(1, 2);
        xfer(1, 1'b1, 8'h48, 4'hC, 32'h0, 8, 1'b0, 32'h0);
        idle_cycles(1, 2);
        xfer(1, 1'b0, 8'hFC, 4'h1, 32'hA5A5_0001, 30, 1'b0, 32'h0);
        idle_cycles(1, 2);

        // Back-to-back alternating writes and reads.
        for (int i = 0; i < 6; i++)
            xfer(0, 1'(i % 2), 8'($urandom), 4'($urandom), $urandom, 0, 1'b0, 32'h0);
        idle_cycles(0, 2);

        // Asynchronous reset during the strobe of a read.
        s_read[0] = 1'b1; s_address[0] = 8'h08; s_byteenable[0] = 4'hF; p_ready[0] = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst pre read_n", 64'(p_read_n[0]), 64'(0));
        #2 reset_n = 1'b0;
        #1;
        check("rst async strobes", 64'({p_chipselect_n[0], p_read_n[0], p_write_n[0]}), 64'(3'b111));
        s_read[0] = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        pending_rdv[0] = 1'b0;
        idle_cycles(0, 4);
        xfer(0, 1'b1, 8'h08, 4'hF, 32'h0, 1, 1'b0, 32'h0);
        idle_cycles(0, 2);

        // Randomised transfers on every instance.
        for (int k = 0; k < NI; k++) begin
            to = int'(TMO_C[k]);
            for (int i = 0; i < 30; i++) begin
                r = int'($urandom_range(0, 3));
                case (r)
                    0:       rl = 0;
                    1:       rl = int'($urandom_range(1, 3));
                    2:       rl = (k == 0) ? 5 : to;
                    default: rl = (k == 0) ? int'($urandom_range(0, 6)) : to + int'($urandom_range(1, 3));
                endcase
                xfer(k, 1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), $urandom, rl, 1'b0, 32'h0);
                idle_cycles(k, int'($urandom_range(0, 2)));
            end
            idle_cycles(k, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
